wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage of the 5-stage pipelined RV32I core. It holds the MEM/WB pipeline register and extracts and sign- or zero-extends load data from the synchronous data-memory read word. It selects the write-back value (ALU, memory, PC+4) and drives the register-file write port (WB_RegWrite/WB_rd/WB_WD) that the decode stage's RF consumes. It also counts retired instructions.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
MEM_valid  in  1  MEM stage holds a real instruction
MEM_RegWrite  in  1  instruction writes rd
MEM_rd  in  5  destination register
MEM_WDSel  in  2  write-back source select
MEM_dm_ctrl  in  3  load type
MEM_aluout  in  XLEN  ALU result; also the load address
MEM_pc  in  XLEN  instruction PC
dm_rdata  in  XLEN  aligned word from synchronous DM; valid in the cycle the load occupies WB
stall  in  1  hold the MEM/WB register
flush  in  1  load a bubble into MEM/WB
WB_RegWrite  out  1  RF write enable
WB_rd  out  5  RF write address
WB_WD  out  XLEN  RF write data
WB_valid  out  1  WB holds a real instruction
WB_retire  out  1  one-cycle pulse per retired instruction
instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. At the reset edge:
  - all MEM/WB fields clear;
  - WB_valid=0, WB_RegWrite=0, WB_rd=0, WB_WD=0, WB_retire=0, instret=0;
  - the fired flag clears.
- Reset mid-operation discards the in-flight instruction; there is no RF write in the reset cycle.
- Register update priority: reset > flush > stall > load.
  - flush: valid=0, all other fields 0.
  - stall (no flush): all fields hold.
  - otherwise: capture the MEM_* inputs.
- Latency: an instruction is in WB one cycle after capture. The RF write happens at the end of that cycle.
- Fired flag:
  - Set at the end of the first WB cycle of a valid instruction.
  - Cleared on any new capture or flush.
- Outputs, combinational from the WB register, dm_rdata and the fired flag:
  - WB_RegWrite = valid & RegWrite & (rd!=0) & ~fired. An instruction held by stall writes exactly once.
  - WB_retire = valid & ~fired. instret increments by 1 on each WB_retire and wraps modulo 2^CNT_W.
- WDSel encoding: 00 = aluout; 01 = load data; 10 = pc+4 (mod 2^XLEN); 11 = aluout.
- Load extraction uses registered aluout[1:0] as a = addr:
  - dm_ctrl 000 (word): dm_rdata; a is ignored.
  - 001 (lh): sign-extend halfword a[1] ? [31:16] : [15:0]; a[0] is ignored.
  - 010 (lhu): same halfword, zero-extended.
  - 011 (lb): sign-extend byte a*8 +: 8.
  - 100 (lbu): same byte, zero-extended.
  - 101–111: treated as word.
- WB_rd and WB_WD are driven regardless of WB_RegWrite. WB_WD is 0 when valid=0.
- x0: rd=0 never asserts WB_RegWrite, but the instruction still retires.
- Simultaneous stall and flush: flush wins.

Decomposition:
- Shared package pipe_defs holds:
  - DM_WORD/DM_HALF/DM_HALF_U/DM_BYTE/DM_BYTE_U (000..100);
  - WDSel_FromALU/FromMEM/FromPC (00/01/10).
- The ctrl and EXT modules import the same package.
- One combinational sub-module, load_align (inputs dm_ctrl, addr[1:0], rdata; output ext_data), is reused by the bench model.
- The pipeline register, fired flag and counter stay in wb_stage.

Test Plan:
- ALU write: MEM_valid=1, RegWrite=1, rd=5, WDSel=00, aluout=0x1234 -> next cycle WB_RegWrite=1, WB_rd=5, WB_WD=0x1234, WB_retire=1; instret 0->1.
- Loads with dm_rdata=0x80FF7F01:
  - lb a=1 -> 0x0000007F.
  - lb a=2 -> 0xFFFFFFFF.
  - lbu a=3 -> 0x00000080.
  - lh a=2 -> 0xFFFF80FF.
  - lhu a=0 -> 0x00007F01.
  - lw a=0 -> 0x80FF7F01.
- JAL with WDSel=10, pc=0xFFFFFFFC -> WB_WD=0x00000000 (wrap); pc=0x100 -> 0x104.
- Stall 3 cycles with a valid rd=7 instruction in WB -> WB_RegWrite and WB_retire high only in the first cycle; instret +1 total.
- Flush while stall=1 -> WB_valid=0 next cycle and no write. rd=0 with RegWrite=1 -> WB_RegWrite=0, instret still +1.
- reset=1 asserted mid-stream, with a valid instruction in WB -> after the edge all outputs are 0 and instret=0. Deasserting reset resumes normal capture.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared pipeline encodings: load-type selects and write-back source selects.
package pipe_defs;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts a byte/halfword/word from an aligned memory word and sign- or zero-extends it.
module load_align
  import pipe_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      dm_ctrl,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    byte_v = rdata[{addr, 3'b000} +: 8];
    case (dm_ctrl)
      DM_HALF:   ext_data = {{(XLEN-16){half_v[15]}}, half_v};
      DM_HALF_U: ext_data = {{(XLEN-16){1'b0}}, half_v};
      DM_BYTE:   ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      DM_BYTE_U: ext_data = {{(XLEN-8){1'b0}}, byte_v};
      // Word and the unused encodings pass the word through.
      default:   ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load extraction, write-back mux and retire counter.
module wb_stage
  import pipe_defs::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MEM_valid,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_rd,
  input  logic [1:0]       MEM_WDSel,
  input  logic [2:0]       MEM_dm_ctrl,
  input  logic [XLEN-1:0]  MEM_aluout,
  input  logic [XLEN-1:0]  MEM_pc,
  input  logic [XLEN-1:0]  dm_rdata,
  input  logic             stall,
  input  logic             flush,
  output logic             WB_RegWrite,
  output logic [4:0]       WB_rd,
  output logic [XLEN-1:0]  WB_WD,
  output logic             WB_valid,
  output logic             WB_retire,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       wdsel_q, wdsel_d;
  logic [2:0]       dm_ctrl_q, dm_ctrl_d;
  logic [XLEN-1:0]  aluout_q, aluout_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fired_q, fired_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  load_data;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .dm_ctrl  (dm_ctrl_q),
    .addr     (aluout_q[1:0]),
    .rdata    (dm_rdata),
    .ext_data (load_data)
  );

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wdsel_d    = wdsel_q;
    dm_ctrl_d  = dm_ctrl_q;
    aluout_d   = aluout_q;
    pc_d       = pc_q;
    fired_d    = 1'b0;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      wdsel_d    = '0;
      dm_ctrl_d  = '0;
      aluout_d   = '0;
      pc_d       = '0;
    end else if (stall) begin
      // A held instruction must write and retire only once.
      fired_d = fired_q | valid_q;
    end else begin
      valid_d    = MEM_valid;
      regwrite_d = MEM_RegWrite;
      rd_d       = MEM_rd;
      wdsel_d    = MEM_WDSel;
      dm_ctrl_d  = MEM_dm_ctrl;
      aluout_d   = MEM_aluout;
      pc_d       = MEM_pc;
    end
  end

  always_comb begin
    // Reset gating keeps the in-flight instruction from writing in the reset cycle.
    WB_retire   = valid_q & ~fired_q & ~reset;
    WB_RegWrite = WB_retire & regwrite_q & (rd_q != 5'd0);
    WB_rd       = rd_q;
    WB_valid    = valid_q;
    instret     = instret_q;
    instret_d   = instret_q + CNT_W'(WB_retire);
    WB_WD       = '0;
    if (valid_q) begin
      case (wdsel_q)
        WDSel_FromMEM: WB_WD = load_data;
        WDSel_FromPC:  WB_WD = pc_q + XLEN'(4);
        default:       WB_WD = aluout_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdsel_q    <= '0;
      dm_ctrl_q  <= '0;
      aluout_q   <= '0;
      pc_q       <= '0;
      fired_q    <= 1'b0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdsel_q    <= wdsel_d;
      dm_ctrl_q  <= dm_ctrl_d;
      aluout_q   <= aluout_d;
      pc_q       <= pc_d;
      fired_q    <= fired_d;
      instret_q  <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage: expected WB outputs are queued at drive time.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_valid, MEM_RegWrite;
  logic [4:0]  MEM_rd;
  logic [1:0]  MEM_WDSel;
  logic [2:0]  MEM_dm_ctrl;
  logic [31:0] MEM_aluout, MEM_pc, dm_rdata;
  logic        stall, flush;
  logic        WB_RegWrite, WB_valid, WB_retire;
  logic [4:0]  WB_rd;
  logic [31:0] WB_WD;
  logic [63:0] instret;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        ret;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_instret = '0;
  logic        pending_ret = 1'b0;

  wb_stage #(
    .XLEN  (32),
    .CNT_W (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_valid    (MEM_valid),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_rd       (MEM_rd),
    .MEM_WDSel    (MEM_WDSel),
    .MEM_dm_ctrl  (MEM_dm_ctrl),
    .MEM_aluout   (MEM_aluout),
    .MEM_pc       (MEM_pc),
    .dm_rdata     (dm_rdata),
    .stall        (stall),
    .flush        (flush),
    .WB_RegWrite  (WB_RegWrite),
    .WB_rd        (WB_rd),
    .WB_WD        (WB_WD),
    .WB_valid     (WB_valid),
    .WB_retire    (WB_retire),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] ctrl,
                       input logic [31:0] alu, input logic [31:0] pc);
    MEM_valid    = v;
    MEM_RegWrite = rw;
    MEM_rd       = rd;
    MEM_WDSel    = sel;
    MEM_dm_ctrl  = ctrl;
    MEM_aluout   = alu;
    MEM_pc       = pc;
  endtask

  task automatic push(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [31:0] wd, input logic ret);
    exp_t e;
    e.v = v; e.rw = rw; e.rd = rd; e.wd = wd; e.ret = ret;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare WB outputs against the oldest queued expectation.
  task automatic tick_check(input string tag);
    exp_t e;
    logic rst_at_edge;
    rst_at_edge = reset;
    @(posedge clk);
    #1;
    exp_instret = rst_at_edge ? 64'd0 : exp_instret + 64'(pending_ret);
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"},  64'(WB_valid),    64'(e.v));
    chk({tag, ".rw"},     64'(WB_RegWrite), 64'(e.rw));
    chk({tag, ".rd"},     64'(WB_rd),       64'(e.rd));
    chk({tag, ".wd"},     64'(WB_WD),       64'(e.wd));
    chk({tag, ".retire"}, 64'(WB_retire),   64'(e.ret));
    chk({tag, ".instret"}, instret,         exp_instret);
    pending_ret = e.ret;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    dm_rdata = 32'h80FF7F01;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0); tick_check("reset0");
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0); tick_check("reset1");
    reset = 1'b0;

    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0);
    push(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b1); tick_check("alu");

    // Loads against dm_rdata = 0x80FF7F01.
    drive(1'b1, 1'b1, 5'd1, 2'b01, 3'b011, 32'h0000_1001, 32'h0);
    push(1'b1, 1'b1, 5'd1, 32'h0000_007F, 1'b1); tick_check("lb_a1");
    drive(1'b1, 1'b1, 5'd2, 2'b01, 3'b011, 32'h0000_1002, 32'h0);
    push(1'b1, 1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1); tick_check("lb_a2");
    drive(1'b1, 1'b1, 5'd3, 2'b01, 3'b100, 32'h0000_1003, 32'h0);
    push(1'b1, 1'b1, 5'd3, 32'h0000_0080, 1'b1); tick_check("lbu_a3");
    drive(1'b1, 1'b1, 5'd4, 2'b01, 3'b001, 32'h0000_1002, 32'h0);
    push(1'b1, 1'b1, 5'd4, 32'hFFFF_80FF, 1'b1); tick_check("lh_a2");
    drive(1'b1, 1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_1000, 32'h0);
    push(1'b1, 1'b1, 5'd6, 32'h0000_7F01, 1'b1); tick_check("lhu_a0");
    drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b000, 32'h0000_1000, 32'h0);
    push(1'b1, 1'b1, 5'd8, 32'h80FF_7F01, 1'b1); tick_check("lw_a0");
    drive(1'b1, 1'b1, 5'd9, 2'b01, 3'b110, 32'h0000_1003, 32'h0);
    push(1'b1, 1'b1, 5'd9, 32'h80FF_7F01, 1'b1); tick_check("ld_rsvd");

    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC);
    push(1'b1, 1'b1, 5'd1, 32'h0000_0000, 1'b1); tick_check("jal_wrap");
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0000_0100);
    push(1'b1, 1'b1, 5'd1, 32'h0000_0104, 1'b1); tick_check("jal_100");
    drive(1'b1, 1'b1, 5'd10, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h0000_0200);
    push(1'b1, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1); tick_check("sel11");

    // Stall holds rd=7 for three cycles; only the first WB cycle writes/retires.
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0777, 32'h0);
    push(1'b1, 1'b1, 5'd7, 32'h0000_0777, 1'b1); tick_check("stall_c0");
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_0BAD, 32'h0);
    push(1'b1, 1'b0, 5'd7, 32'h0000_0777, 1'b0); tick_check("stall_c1");
    push(1'b1, 1'b0, 5'd7, 32'h0000_0777, 1'b0); tick_check("stall_c2");
    push(1'b1, 1'b0, 5'd7, 32'h0000_0777, 1'b0); tick_check("stall_c3");

    // Flush wins over a simultaneous stall.
    flush = 1'b1;
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0); tick_check("flush_stall");
    flush = 1'b0;
    stall = 1'b0;

    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_5555, 32'h0);
    push(1'b1, 1'b0, 5'd0, 32'h0000_5555, 1'b1); tick_check("x0");

    drive(1'b1, 1'b0, 5'd11, 2'b00, 3'b000, 32'h0000_0011, 32'h0);
    push(1'b1, 1'b0, 5'd11, 32'h0000_0011, 1'b1); tick_check("norw");

    // Mid-stream reset with an unfired valid instruction in WB.
    drive(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_1313, 32'h0);
    push(1'b1, 1'b1, 5'd13, 32'h0000_1313, 1'b1); tick_check("pre_rst");
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h0000_1414, 32'h0);
    #1;
    chk("rst_cycle.rw",     64'(WB_RegWrite), 64'd0);
    chk("rst_cycle.retire", 64'(WB_retire),   64'd0);
    pending_ret = 1'b0;
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0); tick_check("rst_mid");
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd15, 2'b00, 3'b000, 32'h0000_1515, 32'h0);
    push(1'b1, 1'b1, 5'd15, 32'h0000_1515, 1'b1); tick_check("post_rst");
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
    push(1'b0, 1'b0, 5'd0, 32'h0, 1'b0); tick_check("bubble");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
